// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between the
// ALU writeback (requester 0) and the load/immediate path (requester 1).
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  req0Valid,
    input  logic [ADDR_WIDTH-1:0] req0Addr,
    input  logic [DATA_WIDTH-1:0] req0Data,
    output logic                  req0Ready,
    input  logic                  req1Valid,
    input  logic [ADDR_WIDTH-1:0] req1Addr,
    input  logic [DATA_WIDTH-1:0] req1Data,
    output logic                  req1Ready,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  lastGrant,
    output logic [CNT_WIDTH-1:0]  conflictCount
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic                  r_last_grant;
    logic [CNT_WIDTH-1:0]  r_conflict_count;

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_contend;

    // Grant: on a tie the requester that did not win last time goes next.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst_n && !stall) begin
            if (req0Valid && req1Valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = !r_last_grant;
            end else begin
                w_grant0 = req0Valid;
                w_grant1 = req1Valid;
            end
        end
    end

    assign w_contend = req0Valid && req1Valid && !stall;

    // Registered write port, grant history and debug contention counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_write      <= 1'b0;
            r_rd             <= '0;
            r_write_data     <= '0;
            r_last_grant     <= 1'b1;
            r_conflict_count <= '0;
        end else begin
            r_reg_write <= w_grant0 || w_grant1;
            if (w_grant0) begin
                r_rd         <= req0Addr;
                r_write_data <= req0Data;
                r_last_grant <= 1'b0;
            end else if (w_grant1) begin
                r_rd         <= req1Addr;
                r_write_data <= req1Data;
                r_last_grant <= 1'b1;
            end
            if (w_contend && (r_conflict_count != CNT_MAX)) begin
                r_conflict_count <= r_conflict_count + CNT_WIDTH'(1);
            end
        end
    end

    assign req0Ready     = w_grant0;
    assign req1Ready     = w_grant1;
    assign regWrite      = r_reg_write;
    assign rd            = r_rd;
    assign writeData     = r_write_data;
    assign lastGrant     = r_last_grant;
    assign conflictCount = r_conflict_count;

endmodule
